logic_unit_seq: RTL and testbench

//  Multi-cycle, parametrised bitwise logic unit for the ALU; successor to the fixed 32-bit XOR.

---
 rtl/logic_unit_seq.sv | 125 ++++++++++++
 tb/tb_logic_unit_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: applies one of eight logic ops to WIDTH-bit operands,
// SLICE bits per clock (LSB slice first), with a start/busy/done handshake and zero/parity flags.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             busy,
    output logic             done
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_op;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_parity;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_last;
    logic [SLICE-1:0]  w_a_slice;
    logic [SLICE-1:0]  w_b_slice;
    logic [SLICE-1:0]  w_slice_res;
    logic [WIDTH-1:0]  w_result_next;

    // start is only honoured outside RUN, so a DONE cycle with start=1 chains the next op
    assign w_accept  = start && (r_state != ST_RUN);
    assign w_last    = (r_idx == IDXW'(NSLICE - 1));
    assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
    assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

    always_comb begin
        w_slice_res = w_b_slice;
        case (r_op)
            3'b000:  w_slice_res = w_a_slice & w_b_slice;
            3'b001:  w_slice_res = w_a_slice | w_b_slice;
            3'b010:  w_slice_res = w_a_slice ^ w_b_slice;
            3'b011:  w_slice_res = ~(w_a_slice | w_b_slice);
            3'b100:  w_slice_res = ~(w_a_slice ^ w_b_slice);
            3'b101:  w_slice_res = ~(w_a_slice & w_b_slice);
            3'b110:  w_slice_res = ~w_a_slice;
            default: w_slice_res = w_b_slice;
        endcase
    end

    // Only the slice selected by r_idx is replaced; the rest keep their current value
    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign w_result_next[gi*SLICE +: SLICE] =
                (r_idx == IDXW'(gi)) ? w_slice_res : r_result[gi*SLICE +: SLICE];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= op;
                r_idx    <= '0;
                r_result <= '0;
            end else if (r_state == ST_RUN) begin
                r_result <= w_result_next;
                if (w_last) begin
                    r_zero   <= ~|w_result_next;
                    r_parity <= ^w_result_next;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign parity = r_parity;
    assign busy   = r_busy;
    assign done   = r_done;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: a 4-slice instance for the handshake and op checks,
// plus a single-slice instance for the one-cycle configuration.
module tb_logic_unit_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        zero, parity, busy, done;

    logic        s_start = 1'b0;
    logic [2:0]  s_op = 3'd0;
    logic [31:0] s_a = '0;
    logic [31:0] s_b = '0;
    logic [31:0] s_result;
    logic        s_zero, s_parity, s_busy, s_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .zero(zero), .parity(parity), .busy(busy), .done(done)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .result(s_result), .zero(s_zero), .parity(s_parity), .busy(s_busy), .done(s_done)
    );

    // busy and done must never be high together on either instance
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((busy && done) || (s_busy && s_done)) begin
                errors++;
                $display("FAIL busy_done_exclusive: busy=%b done=%b s_busy=%b s_done=%b required not both high",
                         busy, done, s_busy, s_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 4-slice instance and wait (bounded) for done; lat=-1 on timeout
    task automatic do_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                         output int lat);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        $display("op=%0d a=%08h b=%08h -> result=%08h zero=%b parity=%b latency=%0d",
                 t_op, t_a, t_b, result, zero, parity, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %08h want 00000000", result); end
        checks++; if (zero !== 1'b0)    begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
        checks++; if (parity !== 1'b0)  begin errors++; $display("FAIL reset_parity: got %b want 0", parity); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (s_result !== 32'h0) begin errors++; $display("FAIL reset_s_result: got %08h want 00000000", s_result); end
    endtask

    task automatic test_xor();
        int lat;
        do_op(3'b010, 32'h00000000, 32'hFFFFFFFF, lat);
        checks++; if (lat != 4)              begin errors++; $display("FAIL xor1_latency: got %0d want 4", lat); end
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL xor1_result: got %08h want FFFFFFFF", result); end
        checks++; if (zero !== 1'b0)         begin errors++; $display("FAIL xor1_zero: got %b want 0", zero); end
        checks++; if (parity !== 1'b0)       begin errors++; $display("FAIL xor1_parity: got %b want 0", parity); end
        tick();
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL result_hold_idle: got %08h want FFFFFFFF", result); end

        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL xor2_result: got %08h want 00000000", result); end
        checks++; if (zero !== 1'b1)         begin errors++; $display("FAIL xor2_zero: got %b want 1", zero); end
        checks++; if (parity !== 1'b0)       begin errors++; $display("FAIL xor2_parity: got %b want 0", parity); end

        do_op(3'b010, 32'h54001000, 32'hE0001FFF, lat);
        checks++; if (result !== 32'hB4000FFF) begin errors++; $display("FAIL xor3_result: got %08h want B4000FFF", result); end
        checks++; if (zero !== 1'b0)         begin errors++; $display("FAIL xor3_zero: got %b want 0", zero); end
        checks++; if (parity !== 1'b0)       begin errors++; $display("FAIL xor3_parity: got %b want 0", parity); end
        tick();
    endtask

    task automatic test_all_ops();
        logic [31:0] exp_res [8];
        int lat;
        exp_res[0] = 32'h000000FF;
        exp_res[1] = 32'h00FFFFFF;
        exp_res[2] = 32'h00FFFF00;
        exp_res[3] = 32'hFF000000;
        exp_res[4] = 32'hFF0000FF;
        exp_res[5] = 32'hFFFFFF00;
        exp_res[6] = 32'hFFFF0000;
        exp_res[7] = 32'h00FF00FF;
        for (int k = 0; k < 8; k++) begin
            do_op(3'(k), 32'h0000FFFF, 32'h00FF00FF, lat);
            checks++;
            if (lat != 4 || result !== exp_res[k]) begin
                errors++;
                $display("FAIL op%0d_result: got %08h latency %0d want %08h latency 4", k, result, lat, exp_res[k]);
            end
            checks++;
            if (zero !== 1'b0 || parity !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_flags: got zero=%b parity=%b want zero=0 parity=0", k, zero, parity);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = 3'b010; a = 32'h12345678; b = 32'h0F0F0F0F; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        // two cycles into RUN: this request must be dropped
        op = 3'b000; a = 32'hFFFFFFFF; b = 32'h00000000; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hAAAAAAAA; b = 32'h55555555;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
        checks++; if (result !== 32'h1D3B5977) begin errors++; $display("FAIL ignore_result: got %08h want 1D3B5977", result); end
        $display("op=2 a=12345678 b=0F0F0F0F (mid-run start ignored) -> result=%08h", result);

        op = 3'b001; a = 32'hF0000000; b = 32'h0000000F; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        $display("op=1 a=F0000000 b=0000000F (back-to-back) -> result=%08h latency=%0d", result, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        checks++; if (result !== 32'hF000000F) begin errors++; $display("FAIL b2b_result: got %08h want F000000F", result); end
        checks++; if (parity !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL b2b_flags: got zero=%b parity=%b want 0 0", zero, parity);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen_done;
        op = 3'b010; a = 32'h00000000; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %08h want 00000000", result); end
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
        $display("reset mid-run: operation aborted, result=%08h", result);
        do_op(3'b100, 32'h0F0F0F0F, 32'h0F0F0F0F, lat);
        checks++; if (lat != 4 || result !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL after_abort: got %08h latency %0d want FFFFFFFF latency 4", result, lat);
        end
        tick();
    endtask

    task automatic test_slice32();
        s_op = 3'b010; s_a = 32'h0000000F; s_b = 32'h00000001; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL s32_busy: got %b want 1", s_busy); end
        tick();
        $display("slice32 op=2 a=0000000F b=00000001 -> result=%08h parity=%b done=%b", s_result, s_parity, s_done);
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL s32_done: got %b want 1", s_done); end
        checks++; if (s_result !== 32'h0000000E) begin errors++; $display("FAIL s32_result: got %08h want 0000000E", s_result); end
        checks++; if (s_parity !== 1'b1 || s_zero !== 1'b0) begin
            errors++; $display("FAIL s32_flags: got zero=%b parity=%b want zero=0 parity=1", s_zero, s_parity);
        end
        tick();
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL s32_pulse: got %b want 0", s_done); end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_all_ops();
        test_back_to_back();
        test_reset_mid();
        test_slice32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
